// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard
//   Hazard and forwarding controller for the in-order pipeline. It tracks the
//   destination register of every in-flight instruction in a STAGES-deep shift
//   register (entry 1 = EX, entry 2 = MEM, entry 3 = WB). It then produces
//   the ID load-use stall and the per-operand EX forward selects.
//
//   Optional feature macro: PIPE_HAZARD_SCOREBOARD_STALL_CNT_EN
//     When defined, adds stall_cnt_o. This is a saturating 32-bit count of
//     the stall cycles that were not overridden by a flush.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous reset, active low
//   id_valid_i     ID holds a real instruction
//   id_src_i       ID source addresses, operand j at [j*AW +: AW]
//   id_dst_i       ID destination address
//   id_regwrite_i  ID instruction writes a register
//   id_memread_i   ID instruction is a load
//   flush_i        squash the instructions in ID and EX
//   stall_o        hold PC and IF/ID, inject a bubble into EX
//   fwd_sel_o      per-operand EX forward select, field j at [j*SELW +: SELW]
//                  (0 = register file, v = tracker entry v+1)
//   ex_valid_o     EX holds a real instruction
//   stall_cnt_o    stall counter (only with the macro above)
//
// The tracker assumes STAGES >= 2, because the flush squashes entries 1 and 2.

module pipe_hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int NUM_SRC  = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 2,
  parameter int SELW     = $clog2(STAGES)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*AW-1:0]     id_src_i,
  input  logic [AW-1:0]             id_dst_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_memread_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel_o,
`ifdef PIPE_HAZARD_SCOREBOARD_STALL_CNT_EN
  output logic [31:0]               stall_cnt_o,
`endif
  output logic                      ex_valid_o
);

  // Tracker entries, indexed 1..STAGES (entry k is k stages after ID)
  logic [STAGES:1] ent_valid;
  logic [STAGES:1] ent_regwrite;
  logic [STAGES:1] ent_memread;
  logic [AW-1:0]   ent_dst [1:STAGES];

  // Source addresses of the instruction currently in EX
  logic [AW-1:0]   ex_src [NUM_SRC];

  logic            issue;

  // Load-use check: a load that is still too young to forward (entries
  // 1..LOAD_LAT-1) and targets any ID source holds ID. Register 0 is excluded.
  always_comb begin
    logic hazard;
    hazard = 1'b0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = 1; k < LOAD_LAT && k <= STAGES; k++) begin
        if (ent_valid[k] && ent_regwrite[k] && ent_memread[k] &&
            ent_dst[k] == id_src_i[j*AW +: AW] &&
            id_src_i[j*AW +: AW] != '0)
          hazard = 1'b1;
      end
    end
    stall_o = id_valid_i & hazard;
  end

  // Forward select: scan from the oldest entry to the youngest so that the
  // youngest matching writer overwrites older ones. Entry 1 is EX itself and
  // never feeds EX.
  always_comb begin
    fwd_sel_o = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = STAGES; k >= 2; k--) begin
        if (ent_valid[k] && ent_regwrite[k] && ent_dst[k] == ex_src[j] &&
            ex_src[j] != '0)
          fwd_sel_o[j*SELW +: SELW] = SELW'(k - 1);
      end
    end
  end

  assign issue      = id_valid_i & ~stall_o & ~flush_i;
  assign ex_valid_o = ent_valid[1];

  // Tracker shift. Entry 1 takes the ID instruction only when it really
  // advances; otherwise it takes a bubble. A flush also squashes the
  // instruction leaving EX, so entry 2 becomes a bubble instead of receiving
  // the old entry 1.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ent_valid    <= '0;
      ent_regwrite <= '0;
      ent_memread  <= '0;
      for (int k = 1; k <= STAGES; k++) ent_dst[k] <= '0;
      for (int j = 0; j < NUM_SRC; j++) ex_src[j] <= '0;
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        ent_valid[k]    <= ent_valid[k-1];
        ent_regwrite[k] <= ent_regwrite[k-1];
        ent_memread[k]  <= ent_memread[k-1];
        ent_dst[k]      <= ent_dst[k-1];
      end
      if (issue) begin
        ent_valid[1]    <= 1'b1;
        ent_regwrite[1] <= id_regwrite_i;
        ent_memread[1]  <= id_memread_i;
        ent_dst[1]      <= id_dst_i;
        for (int j = 0; j < NUM_SRC; j++) ex_src[j] <= id_src_i[j*AW +: AW];
      end else begin
        ent_valid[1]    <= 1'b0;
        ent_regwrite[1] <= 1'b0;
        ent_memread[1]  <= 1'b0;
        ent_dst[1]      <= '0;
        for (int j = 0; j < NUM_SRC; j++) ex_src[j] <= '0;
      end
      if (flush_i) begin
        ent_valid[2]    <= 1'b0;
        ent_regwrite[2] <= 1'b0;
        ent_memread[2]  <= 1'b0;
        ent_dst[2]      <= '0;
      end
    end
  end

`ifdef PIPE_HAZARD_SCOREBOARD_STALL_CNT_EN
  // Count only the stalls the pipeline honours (a flush overrides a stall).
  // The count saturates at all-ones.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      stall_cnt_o <= '0;
    else if (stall_o && !flush_i && stall_cnt_o != 32'hFFFF_FFFF)
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard
//   Self-checking bench for pipe_hazard_scoreboard with default parameters.
//   A reference model holds the in-flight instructions as a queue of records,
//   with the youngest (EX) at the front. It derives stall, forward selects,
//   EX valid and the optional stall count from those records.
//   Optional feature macro: PIPE_HAZARD_SCOREBOARD_STALL_CNT_EN

module tb_pipe_hazard_scoreboard;

  localparam int STAGES   = 3;
  localparam int NUM_SRC  = 2;
  localparam int AW       = 5;
  localparam int LOAD_LAT = 2;
  localparam int SELW     = $clog2(STAGES);

  typedef struct packed {
    logic                  valid;
    logic [AW-1:0]         dst;
    logic                  rw;
    logic                  mr;
    logic [NUM_SRC*AW-1:0] src;
  } instr_t;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    id_valid_i;
  logic [NUM_SRC*AW-1:0]   id_src_i;
  logic [AW-1:0]           id_dst_i;
  logic                    id_regwrite_i;
  logic                    id_memread_i;
  logic                    flush_i;
  logic                    stall_o;
  logic [NUM_SRC*SELW-1:0] fwd_sel_o;
  logic                    ex_valid_o;
`ifdef PIPE_HAZARD_SCOREBOARD_STALL_CNT_EN
  logic [31:0]             stall_cnt_o;
`endif

  int     checks = 0;
  int     errors = 0;
  instr_t inflight[$];
  logic [31:0] model_cnt;

  pipe_hazard_scoreboard #(
    .STAGES(STAGES), .NUM_SRC(NUM_SRC), .AW(AW),
    .LOAD_LAT(LOAD_LAT), .SELW(SELW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .id_valid_i(id_valid_i),
    .id_src_i(id_src_i),
    .id_dst_i(id_dst_i),
    .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i),
    .flush_i(flush_i),
    .stall_o(stall_o),
    .fwd_sel_o(fwd_sel_o),
`ifdef PIPE_HAZARD_SCOREBOARD_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .ex_valid_o(ex_valid_o)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 clk_i = ~clk_i;

  // An instruction "writes r" when it is real, writes a register, targets r,
  // and r is not register 0.
  function automatic logic writes(instr_t i, logic [AW-1:0] r);
    return i.valid && i.rw && i.dst == r && r != '0;
  endfunction

  // The ID instruction must wait when a load that is still too young to
  // forward (queue positions 0..LOAD_LAT-2) targets one of its sources.
  function automatic logic model_stall();
    logic s;
    s = 1'b0;
    if (id_valid_i)
      for (int j = 0; j < NUM_SRC; j++)
        for (int k = 0; k < LOAD_LAT - 1; k++)
          if (writes(inflight[k], id_src_i[j*AW +: AW]) && inflight[k].mr)
            s = 1'b1;
    return s;
  endfunction

  // After reset, nothing is in flight and the count is zero.
  task automatic model_reset();
    inflight.delete();
    for (int k = 0; k < STAGES; k++) inflight.push_back('0);
    model_cnt = 0;
  endtask

  // One comparison: count it, and report a failure with the observed and
  // expected values.
  task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against what the model predicts for the current
  // inputs and in-flight state. EX forwards from the youngest older writer.
  task automatic check_model();
    instr_t ex;
    logic [31:0] exp_sel;
    ex = inflight[0];
    check_output("stall", 32'(stall_o), 32'(model_stall()));
    for (int j = 0; j < NUM_SRC; j++) begin
      exp_sel = 0;
      for (int k = 1; k < STAGES; k++)
        if (exp_sel == 0 && writes(inflight[k], ex.src[j*AW +: AW]))
          exp_sel = k;
      check_output($sformatf("fwd%0d", j), 32'(fwd_sel_o[j*SELW +: SELW]), exp_sel);
    end
    check_output("ex_valid", 32'(ex_valid_o), 32'(ex.valid));
`ifdef PIPE_HAZARD_SCOREBOARD_STALL_CNT_EN
    check_output("stall_cnt", stall_cnt_o, model_cnt);
`endif
  endtask

  // Drive the ID inputs just after a falling edge, then let them settle.
  task automatic apply_stimulus(logic v, logic [AW-1:0] s0, logic [AW-1:0] s1,
                                logic [AW-1:0] d, logic rw, logic mr, logic fl);
    id_valid_i    = v;
    id_src_i      = {s1, s0};
    id_dst_i      = d;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    flush_i       = fl;
    #1;
  endtask

  // Advance one clock. The model moves every instruction one stage older
  // and admits the ID instruction only if it really advances. A flush kills
  // both the ID instruction and the one leaving EX.
  task automatic tick();
    logic   st, issue;
    instr_t ni;
    st    = model_stall();
    issue = id_valid_i && !st && !flush_i;
    ni    = '0;
    if (issue) begin
      ni.valid = 1'b1;
      ni.dst   = id_dst_i;
      ni.rw    = id_regwrite_i;
      ni.mr    = id_memread_i;
      ni.src   = id_src_i;
    end
    @(posedge clk_i);
    if (flush_i) inflight[0] = '0;
    inflight.push_front(ni);
    void'(inflight.pop_back());
    if (st && !flush_i && model_cnt != 32'hFFFF_FFFF) model_cnt++;
    @(negedge clk_i);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      check_model();
      tick();
    end
  endtask

  // Directed scenarios followed by a randomized run. All cases are checked
  // against the model every cycle, with constant spot checks at the key
  // points.
  initial begin
    rst_i = 1'b0;
    apply_stimulus(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom));
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    check_output("reset_stall", 32'(stall_o), 0);
    check_output("reset_fwd", 32'(fwd_sel_o), 0);
    check_output("reset_ex_valid", 32'(ex_valid_o), 0);
    check_model();
    tick();

    $display("[TB] EX forwarding from MEM and WB");
    apply_stimulus(1, 0, 0, 8, 1, 0, 0);   check_model(); tick();
    apply_stimulus(1, 8, 9, 10, 1, 0, 0);  check_model(); tick();
    apply_stimulus(1, 8, 0, 11, 1, 0, 0);  check_model();
    check_output("mem_fwd0", 32'(fwd_sel_o[0 +: SELW]), 1);
    check_output("mem_fwd1", 32'(fwd_sel_o[SELW +: SELW]), 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);   check_model();
    check_output("wb_fwd0", 32'(fwd_sel_o[0 +: SELW]), 2);
    tick();
    idle(3);

    $display("[TB] youngest writer wins");
    apply_stimulus(1, 0, 0, 5, 1, 0, 0);   check_model(); tick();
    apply_stimulus(1, 0, 0, 5, 1, 0, 0);   check_model(); tick();
    apply_stimulus(1, 0, 5, 12, 1, 0, 0);  check_model(); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);   check_model();
    check_output("prio_fwd1", 32'(fwd_sel_o[SELW +: SELW]), 1);
    tick();
    idle(3);

    $display("[TB] load-use stall");
    apply_stimulus(1, 0, 0, 4, 1, 1, 0);   check_model(); tick();
    apply_stimulus(1, 4, 0, 13, 1, 0, 0);  check_model();
    check_output("lu_stall", 32'(stall_o), 1);
    tick();
    apply_stimulus(1, 4, 0, 13, 1, 0, 0);  check_model();
    check_output("lu_stall_end", 32'(stall_o), 0);
    check_output("lu_bubble", 32'(ex_valid_o), 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);   check_model();
    check_output("lu_fwd0", 32'(fwd_sel_o[0 +: SELW]), 2);
    check_output("lu_ex_valid", 32'(ex_valid_o), 1);
`ifdef PIPE_HAZARD_SCOREBOARD_STALL_CNT_EN
    check_output("lu_cnt", stall_cnt_o, 1);
`endif
    tick();
    idle(3);

    $display("[TB] register 0 never matches");
    apply_stimulus(1, 0, 0, 0, 1, 0, 0);   check_model(); tick();
    apply_stimulus(1, 0, 0, 14, 1, 0, 0);  check_model(); tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);   check_model();
    check_output("r0_fwd0", 32'(fwd_sel_o[0 +: SELW]), 0);
    tick();
    apply_stimulus(1, 0, 0, 0, 1, 1, 0);   check_model(); tick();
    apply_stimulus(1, 0, 0, 15, 1, 0, 0);  check_model();
    check_output("r0_stall", 32'(stall_o), 0);
    tick();
    idle(3);

    $display("[TB] flush squashes ID and EX");
    apply_stimulus(1, 0, 0, 4, 1, 1, 0);   check_model(); tick();
    apply_stimulus(1, 4, 0, 16, 1, 0, 1);  check_model();
    check_output("fl_hazard", 32'(stall_o), 1);
    tick();
    apply_stimulus(1, 4, 0, 16, 1, 0, 0);  check_model();
    check_output("fl_stall", 32'(stall_o), 0);
    check_output("fl_ex_valid", 32'(ex_valid_o), 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);   check_model();
    check_output("fl_no_fwd", 32'(fwd_sel_o[0 +: SELW]), 0);
    check_output("fl_ex_valid2", 32'(ex_valid_o), 1);
    tick();
    idle(3);

    $display("[TB] asynchronous reset mid-stream");
    apply_stimulus(1, 0, 0, 6, 1, 0, 0);   check_model(); tick();
    apply_stimulus(1, 6, 6, 7, 1, 1, 0);   check_model(); tick();
    apply_stimulus(1, 7, 0, 3, 1, 0, 0);   check_model();
    #2;
    rst_i = 1'b0;
    #1;
    check_output("arst_stall", 32'(stall_o), 0);
    check_output("arst_fwd", 32'(fwd_sel_o), 0);
    check_output("arst_ex_valid", 32'(ex_valid_o), 0);
`ifdef PIPE_HAZARD_SCOREBOARD_STALL_CNT_EN
    check_output("arst_cnt", stall_cnt_o, 0);
`endif
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 9) < 8),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)),
                     1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 3),
                     1'($urandom_range(0, 9) == 0));
      check_model();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_scoreboard.md
Name: pipe_hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order pipeline. It replaces the fixed 2-operand, 3-stage forwarding unit and the load-use detector with one block.
- Tracks the destination register of every in-flight instruction in a shift register of STAGES entries: entry 1 = EX, entry 2 = MEM, entry 3 = WB.
- Stall decision is made in ID, with configurable load-data latency.
- Forwarding selects are generated for the NUM_SRC operands of the instruction currently in EX.

Parameters:
- STAGES, 3: tracked post-ID stages; entry k sits k stages after ID.
- NUM_SRC, 2: source operands per instruction.
- AW, 5: register address width.
- LOAD_LAT, 2: first entry index whose load result can be forwarded. A load in entries 1..LOAD_LAT-1 forces a stall.
- SELW, $clog2(STAGES): width of each forward select field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset. Asynchronous, active-low.
- id_valid_i  in  1  ID stage holds a real instruction.
- id_src_i  in  NUM_SRC*AW  ID source addresses; operand j occupies bits [j*AW +: AW].
- id_dst_i  in  AW  ID destination address (after RegDst mux).
- id_regwrite_i  in  1  ID instruction writes a register.
- id_memread_i  in  1  ID instruction is a load.
- flush_i  in  1  squash the instructions in ID and EX (branch taken).
- stall_o  out  1  hold PC and IF/ID; inject a bubble into EX.
- fwd_sel_o  out  NUM_SRC*SELW  per-operand EX forward select. 0 = register file; v = entry v+1.
- ex_valid_o  out  1  EX entry holds a real instruction.
- stall_cnt_o  out  32  only present with STALL_CNT_EN.

Behaviour:
- Entry fields: valid, dst, regwrite, memread. The block also keeps NUM_SRC registered EX source addresses.
- Reset (rst_i low, asynchronous): all entries invalid, all fields 0, EX source addresses 0. Consequently stall_o=0, fwd_sel_o=0, ex_valid_o=0.
- An entry "writes r" only if valid & regwrite & dst==r & r!=0. Register 0 never matches, never stalls and never forwards.
- stall_o (combinational) = id_valid_i AND there exist j and k in 1..LOAD_LAT-1 such that entry k writes id_src[j] AND entry k has memread=1.
- With LOAD_LAT=1, stall_o is constant 0.
- Each rising edge, normal operation:
  - entry k+1 <= entry k, for k = 1..STAGES-1; the last entry is discarded.
  - entry 1 <= {1, id_dst_i, id_regwrite_i, id_memread_i} and EX sources <= id_src_i, only when id_valid_i & ~stall_o & ~flush_i.
  - Otherwise entry 1 <= bubble (all zero) and EX sources <= 0.
- Flush: on an edge with flush_i=1, entry 1 <= bubble and entry 2 <= bubble (the instruction leaving EX is squashed). Entries 3 and beyond shift normally.
- Flush together with stall: flush wins for the tracker update. stall_o still reflects the hazard equation; the pipeline ignores it under flush.
- fwd_sel_o field j (combinational from registered state):
  - Scan entries k = 2..STAGES, youngest (smallest k) first.
  - First entry that writes EX source j gives value k-1.
  - No match gives 0.
  - Entry 1 is never a forward source for EX.
  - With the defaults: 1 = MEM, 2 = WB.
- ex_valid_o = entry 1 valid.
- A load in entry k >= LOAD_LAT is a legal forward source.
- No latency beyond the combinational outputs. The tracker is a pure one-cycle-per-stage shift.

Optional Feature:
- Macro: PIPE_HAZARD_SCOREBOARD_STALL_CNT_EN.
- Defined:
  - stall_cnt_o is a 32-bit counter, reset to 0 asynchronously.
  - Increments on every edge where stall_o=1 and flush_i=0.
  - Saturates at 32'hFFFFFFFF; does not wrap.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with arbitrary inputs, then release -> stall_o=0, fwd_sel_o=0, ex_valid_o=0.
- EX->EX forward: issue dst=r8 regwrite, then next cycle issue src0=r8, src1=r9 -> once the second instruction is in EX, fwd_sel_o field0=1, field1=0. One cycle later with a nop in ID, the producer is in WB -> a consumer issued then sees field0=2.
- Priority: two back-to-back writers of r5, then consumer src1=r5 -> field1=1 (the younger MEM writer), not 2.
- Load-use: load dst=r4, next ID src0=r4 -> stall_o=1 for exactly 1 cycle. Bubble appears in EX (ex_valid_o=0). Consumer then issues with field0=2 (WB). With STALL_CNT_EN, stall_cnt_o=1.
- r0: writer dst=r0, then consumer src0=r0 -> field0=0. Load to r0 followed by src r0 -> stall_o=0.
- Flush: load r4 in EX, flush_i=1 while ID has src r4 -> next cycle entries 1 and 2 are invalid, stall_o=0 and no forward to r4. Separately, assert rst_i mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
